if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Purpose:
//   Holds the program counter and presents it to the instruction SRAM. It
//   advances by 4 each unstalled cycle, or jumps when decode redirects it.
//   A redirect that arrives while IF is stalled is parked and applied on the
//   first unstalled edge. The stage also keeps a copy of the fetched word so
//   decode still sees the right instruction while ID and EX are frozen.
//
// Ports:
//   clk              in   1   core clock
//   rst              in   1   synchronous active-high reset
//   stall            in   6   stall vector; bit0=IF, bit1=ID, bit2=EX (1=stop)
//   br_bus           in  33   {br_e, br_addr[31:0]} redirect from decode
//   if_to_id_bus     out 33   {ce, pc[31:0]} to decode
//   inst_sram_en     out  1   instruction SRAM enable
//   inst_sram_wen    out  4   SRAM byte write enables (always zero)
//   inst_sram_addr   out 32   fetch address
//   inst_sram_wdata  out 32   SRAM write data (always zero)
//   inst_sram_rdata  in  32   SRAM read data, one cycle after the address
//   id_inst          out 32   instruction for decode, held across ID/EX stalls
//
// Parameters:
//   RESET_PC   PC value after reset; the first real fetch is RESET_PC+4.
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] id_inst
);

    // Architectural state
    logic [31:0] pc_reg_q,       pc_reg_d;
    logic        ce_reg_q,       ce_reg_d;
    logic        br_pend_v_q,    br_pend_v_d;
    logic [31:0] br_pend_addr_q, br_pend_addr_d;
    logic        hold_v_q,       hold_v_d;
    logic [31:0] inst_buf_q,     inst_buf_d;

    // Decoded inputs
    logic        br_e_s;
    logic [31:0] br_addr_s;
    logic [31:0] next_pc_s;
    logic        stall_if_s;
    logic        stall_id_s;
    logic        stall_ex_s;

    // Stall bits above EX belong to later stages and do not affect fetch.
    logic        unused_stall_s;

    assign br_e_s         = br_bus[32];
    assign br_addr_s      = br_bus[31:0];
    assign stall_if_s     = stall[0];
    assign stall_id_s     = stall[1];
    assign stall_ex_s     = stall[2];
    assign unused_stall_s = ^stall[5:3];

    // Next fetch address: a live redirect beats a parked one, which beats
    // sequential fetch. The +4 wraps naturally at 32 bits.
    always_comb begin
        if (br_e_s) begin
            next_pc_s = br_addr_s;
        end else if (br_pend_v_q) begin
            next_pc_s = br_pend_addr_q;
        end else begin
            next_pc_s = pc_reg_q + 32'd4;
        end
    end

    // PC / fetch-enable / parked-redirect next state
    always_comb begin
        pc_reg_d       = pc_reg_q;
        ce_reg_d       = ce_reg_q;
        br_pend_v_d    = br_pend_v_q;
        br_pend_addr_d = br_pend_addr_q;
        if (!stall_if_s) begin
            // Advancing consumes any parked redirect through next_pc_s.
            pc_reg_d    = next_pc_s;
            ce_reg_d    = 1'b1;
            br_pend_v_d = 1'b0;
        end else if (br_e_s) begin
            // Stalled: park the redirect; a later one overwrites it.
            br_pend_v_d    = 1'b1;
            br_pend_addr_d = br_addr_s;
        end else begin
            br_pend_v_d    = br_pend_v_q;
            br_pend_addr_d = br_pend_addr_q;
        end
    end

    // Instruction hold buffer next state. The SRAM word for the PC decode is
    // holding is only valid in the first stalled cycle, so it is captured
    // once and kept until ID moves or a decode bubble discards it.
    always_comb begin
        hold_v_d   = hold_v_q;
        inst_buf_d = inst_buf_q;
        if (!stall_id_s) begin
            hold_v_d = 1'b0;
        end else if (!stall_ex_s) begin
            hold_v_d = 1'b0;
        end else if (!hold_v_q) begin
            hold_v_d   = 1'b1;
            inst_buf_d = inst_sram_rdata;
        end else begin
            hold_v_d   = hold_v_q;
            inst_buf_d = inst_buf_q;
        end
    end

    // State registers with synchronous reset; reset discards any parked
    // redirect and buffered instruction regardless of stall or br_bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg_q       <= RESET_PC;
            ce_reg_q       <= 1'b0;
            br_pend_v_q    <= 1'b0;
            br_pend_addr_q <= 32'h0000_0000;
            hold_v_q       <= 1'b0;
            inst_buf_q     <= 32'h0000_0000;
        end else begin
            pc_reg_q       <= pc_reg_d;
            ce_reg_q       <= ce_reg_d;
            br_pend_v_q    <= br_pend_v_d;
            br_pend_addr_q <= br_pend_addr_d;
            hold_v_q       <= hold_v_d;
            inst_buf_q     <= inst_buf_d;
        end
    end

    // Outputs: all fetch-side outputs come straight from registers; the
    // instruction path selects the buffered word while it is valid.
    assign if_to_id_bus    = {ce_reg_q, pc_reg_q};
    assign inst_sram_en    = ce_reg_q;
    assign inst_sram_addr  = pc_reg_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;
    assign id_inst         = hold_v_q ? inst_buf_q : inst_sram_rdata;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage
//
// Each table row is the input set held for one clock; after the edge the
// fetch address, ce, decode bus, SRAM controls and id_inst are compared with
// hand-computed values. A hand-written long-stall sequence follows.
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [31:0] id_inst;

    int checks   = 0;
    int failures = 0;

    if_stage #(.RESET_PC(32'hBFBF_FFFC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .id_inst         (id_inst)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, need completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic [32:0] br;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
        logic        exp_ce;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [5:0] s,
                                input logic [32:0] b, input logic [31:0] rd,
                                input logic [31:0] pc, input logic ce,
                                input logic [31:0] inst);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.rdata = rd;
        v.exp_pc = pc; v.exp_ce = ce; v.exp_inst = inst;
        return v;
    endfunction

    task automatic check(input string name, input logic [32:0] act,
                         input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] pc,
                                 input logic ce, input logic [31:0] inst);
        check({tag, " addr"},  {1'b0, inst_sram_addr}, {1'b0, pc});
        check({tag, " en"},    {32'h0, inst_sram_en}, {32'h0, ce});
        check({tag, " bus"},   if_to_id_bus, {ce, pc});
        check({tag, " inst"},  {1'b0, id_inst}, {1'b0, inst});
        check({tag, " wen"},   {29'h0, inst_sram_wen}, 33'h0);
        check({tag, " wdata"}, {1'b0, inst_sram_wdata}, 33'h0);
    endtask

    localparam logic [32:0] NB = 33'h0_0000_0000;

    initial begin
        rst = 1'b1; stall = 6'b0; br_bus = NB; inst_sram_rdata = 32'h0;

        // rst  stall      br_bus                 rdata          exp_pc         ce    exp_inst
        // reset, including with stall and redirect present
        vecs.push_back(mk(1'b1, 6'h00, NB,                    32'h0000_0001, 32'hBFBF_FFFC, 1'b0, 32'h0000_0001));
        vecs.push_back(mk(1'b1, 6'h3F, {1'b1, 32'hDEAD_0000}, 32'h0000_0002, 32'hBFBF_FFFC, 1'b0, 32'h0000_0002));
        // release: sequential fetch
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'h0000_0003, 32'hBFC0_0000, 1'b1, 32'h0000_0003));
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'h0000_0004, 32'hBFC0_0004, 1'b1, 32'h0000_0004));
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'h0000_0005, 32'hBFC0_0008, 1'b1, 32'h0000_0005));
        // unstalled redirect at BFC0_0008
        vecs.push_back(mk(1'b0, 6'h00, {1'b1, 32'hBFC0_0100}, 32'h0000_0006, 32'hBFC0_0100, 1'b1, 32'h0000_0006));
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'h0000_0007, 32'hBFC0_0104, 1'b1, 32'h0000_0007));
        // get to BFC0_0010
        vecs.push_back(mk(1'b0, 6'h00, {1'b1, 32'hBFC0_0010}, 32'h0000_0008, 32'hBFC0_0010, 1'b1, 32'h0000_0008));
        // 3-cycle full stall, redirect only in first cycle, hold buffer capture
        vecs.push_back(mk(1'b0, 6'h07, {1'b1, 32'hBFC0_0200}, 32'h3C01_1234, 32'hBFC0_0010, 1'b1, 32'h3C01_1234));
        vecs.push_back(mk(1'b0, 6'h07, NB,                    32'h1111_1111, 32'hBFC0_0010, 1'b1, 32'h3C01_1234));
        vecs.push_back(mk(1'b0, 6'h07, NB,                    32'h2222_2222, 32'hBFC0_0010, 1'b1, 32'h3C01_1234));
        // release: parked redirect taken, buffer released
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'h3333_3333, 32'hBFC0_0200, 1'b1, 32'h3333_3333));
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'h3333_3334, 32'hBFC0_0204, 1'b1, 32'h3333_3334));
        // decode bubble: no capture, address held one cycle
        vecs.push_back(mk(1'b0, 6'h03, NB,                    32'h4444_4444, 32'hBFC0_0204, 1'b1, 32'h4444_4444));
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'h5555_5555, 32'hBFC0_0208, 1'b1, 32'h5555_5555));
        // parked redirect overwritten, then beaten by a live one
        vecs.push_back(mk(1'b0, 6'h01, {1'b1, 32'hBFC0_0300}, 32'h5555_5556, 32'hBFC0_0208, 1'b1, 32'h5555_5556));
        vecs.push_back(mk(1'b0, 6'h01, {1'b1, 32'hBFC0_0400}, 32'h5555_5557, 32'hBFC0_0208, 1'b1, 32'h5555_5557));
        vecs.push_back(mk(1'b0, 6'h00, {1'b1, 32'hBFC0_0500}, 32'h5555_5558, 32'hBFC0_0500, 1'b1, 32'h5555_5558));
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'h5555_5559, 32'hBFC0_0504, 1'b1, 32'h5555_5559));
        // reset mid-stall with a parked redirect and buffered word
        vecs.push_back(mk(1'b0, 6'h07, {1'b1, 32'hBFC0_0600}, 32'hAAAA_AAAA, 32'hBFC0_0504, 1'b1, 32'hAAAA_AAAA));
        vecs.push_back(mk(1'b1, 6'h07, NB,                    32'hBBBB_BBBB, 32'hBFBF_FFFC, 1'b0, 32'hBBBB_BBBB));
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'hCCCC_CCCC, 32'hBFC0_0000, 1'b1, 32'hCCCC_CCCC));
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'hCCCC_CCCD, 32'hBFC0_0004, 1'b1, 32'hCCCC_CCCD));
        // 32-bit wrap
        vecs.push_back(mk(1'b0, 6'h00, {1'b1, 32'hFFFF_FFFC}, 32'hCCCC_CCCE, 32'hFFFF_FFFC, 1'b1, 32'hCCCC_CCCE));
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'hCCCC_CCCF, 32'h0000_0000, 1'b1, 32'hCCCC_CCCF));
        // captured word discarded by a decode bubble
        vecs.push_back(mk(1'b0, 6'h07, NB,                    32'hD000_0000, 32'h0000_0000, 1'b1, 32'hD000_0000));
        vecs.push_back(mk(1'b0, 6'h03, NB,                    32'hD000_0001, 32'h0000_0000, 1'b1, 32'hD000_0001));
        vecs.push_back(mk(1'b0, 6'h00, NB,                    32'hD000_0002, 32'h0000_0004, 1'b1, 32'hD000_0002));

        foreach (vecs[i]) begin
            rst             = vecs[i].rst;
            stall           = vecs[i].stall;
            br_bus          = vecs[i].br;
            inst_sram_rdata = vecs[i].rdata;
            @(posedge clk);
            #1;
            check_outputs($sformatf("row%0d", i), vecs[i].exp_pc,
                          vecs[i].exp_ce, vecs[i].exp_inst);
        end

        // Long stall: same PC re-presented, first word held, then one step
        stall = 6'h07; br_bus = NB; inst_sram_rdata = 32'hE000_0000;
        @(posedge clk);
        #1;
        check_outputs("long_first", 32'h0000_0004, 1'b1, 32'hE000_0000);
        for (int k = 1; k < 20; k++) begin
            inst_sram_rdata = 32'hE000_0000 + k;
            @(posedge clk);
            #1;
            check_outputs($sformatf("long%0d", k), 32'h0000_0004, 1'b1, 32'hE000_0000);
        end
        stall = 6'h00; inst_sram_rdata = 32'hF000_0000;
        @(posedge clk);
        #1;
        check_outputs("long_rel", 32'h0000_0008, 1'b1, 32'hF000_0000);
        inst_sram_rdata = 32'hF000_0001;
        @(posedge clk);
        #1;
        check_outputs("long_next", 32'h0000_000C, 1'b1, 32'hF000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
